// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetch stage: PC, single outstanding cache read, circular instruction queue
// Optional JAL target prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetcher #(
  parameter int          IQ_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] rob_new_pc,
  input  logic        cache_free,
  output logic        out_fetcher_ready,
  output logic [31:0] fetch_addr,
  input  logic        in_cache_ready,
  input  logic [31:0] instr_in,
  input  logic [31:0] instr_addr_in,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        decoder_ready
);

  localparam int                      DEPTH   = 1 << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE = IQ_DEPTH_LOG'(1);
  localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE = (IQ_DEPTH_LOG+1)'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state;
  logic [31:0]             pc;
  logic [IQ_DEPTH_LOG-1:0] head;
  logic [IQ_DEPTH_LOG-1:0] tail;
  logic [IQ_DEPTH_LOG:0]   count;
  logic [31:0]             instr_mem [DEPTH];
  logic [31:0]             pc_mem    [DEPTH];

  logic        push;
  logic        pop;
  logic        iq_full;
  logic [31:0] next_pc;

  // count never exceeds DEPTH, so its top bit alone marks a full queue
  assign iq_full   = count[IQ_DEPTH_LOG];
  assign push      = (state == S_WAIT) && in_cache_ready && (instr_addr_in == fetch_addr);
  assign out_valid = (count != '0);
  assign pop       = out_valid && decoder_ready;
  assign out_instr = instr_mem[head];
  assign out_pc    = pc_mem[head];

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
  assign next_pc = (instr_in[6:0] == 7'b1101111) ? instr_addr_in + jal_imm
                                                 : instr_addr_in + 32'd4;
`else
  assign next_pc = instr_addr_in + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      pc                <= RESET_PC;
      out_fetcher_ready <= 1'b0;
      fetch_addr        <= RESET_PC;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (rdy) begin
      if (rob_clear) begin
        // flush drops queued entries and any response landing this cycle
        head              <= '0;
        tail              <= '0;
        count             <= '0;
        pc                <= rob_new_pc;
        state             <= S_IDLE;
        out_fetcher_ready <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cache_free && !iq_full) begin
              out_fetcher_ready <= 1'b1;
              fetch_addr        <= pc;
              state             <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (push) begin
              instr_mem[tail]   <= instr_in;
              pc_mem[tail]      <= instr_addr_in;
              tail              <= tail + PTR_ONE;
              out_fetcher_ready <= 1'b0;
              pc                <= next_pc;
              state             <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (pop) head <= head + PTR_ONE;
        if (push && !pop) count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - self-checking bench for fetcher: directed scenarios plus randomized run against a queue model
// Build with FETCH_JAL_PREDICT_EN defined to check the JAL prediction variant.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rob_clear;
  logic [31:0] rob_new_pc;
  logic        cache_free;
  logic        out_fetcher_ready;
  logic [31:0] fetch_addr;
  logic        in_cache_ready;
  logic [31:0] instr_in;
  logic [31:0] instr_addr_in;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        decoder_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetcher #(.IQ_DEPTH_LOG(3), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .rob_new_pc(rob_new_pc),
    .cache_free(cache_free), .out_fetcher_ready(out_fetcher_ready), .fetch_addr(fetch_addr),
    .in_cache_ready(in_cache_ready), .instr_in(instr_in), .instr_addr_in(instr_addr_in),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .decoder_ready(decoder_ready)
  );

  // Next fetch address after an accepted word, straight from the architectural rule.
  function automatic logic [31:0] ref_next(input logic [31:0] instr, input logic [31:0] addr);
    int off;
    off = 4;
`ifdef FETCH_JAL_PREDICT_EN
    if (instr[6:0] == 7'h6F) begin
      off = int'(instr[30:21]) * 2 + int'(instr[20]) * 2048 + int'(instr[19:12]) * 4096;
      if (instr[31]) off = off - (1 << 20);
    end
`endif
    return addr + 32'(off);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    rdy = 1'b1; rob_clear = 1'b0; rob_new_pc = '0; cache_free = 1'b0;
    in_cache_ready = 1'b0; instr_in = '0; instr_addr_in = '0; decoder_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!out_fetcher_ready && n < 20) begin
      tick();
      n++;
    end
    ok = out_fetcher_ready;
  endtask

  task automatic serve(input int lat, input logic [31:0] instr, output logic [31:0] addr, output bit ok);
    wait_req(ok);
    addr = fetch_addr;
    repeat (lat - 1) tick();
    in_cache_ready = 1'b1; instr_addr_in = addr; instr_in = instr;
    tick();
    in_cache_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    rdy = 1'b0; rob_clear = 1'b1; rob_new_pc = 32'h1234;
    rst = 1'b1;
    tick(); tick();
    checks++; if (out_fetcher_ready !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", out_fetcher_ready); end
    checks++; if (fetch_addr !== 32'h0) begin errors++; $display("FAIL reset_fetch_addr: got %h expected 00000000", fetch_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", out_pc); end
    rst = 1'b0;
    set_idle_inputs();
    cache_free = 1'b1;
    #1;
    checks++; if (out_fetcher_ready !== 1'b0) begin errors++; $display("FAIL req_registered: got %b expected 0", out_fetcher_ready); end
    tick();
    checks++;
    if (out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", out_fetcher_ready, fetch_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addr;
    bit ok;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve(3, 32'h00000013, addr, ok);
      checks++; if (!ok || addr !== 32'(4 * k)) begin errors++; $display("FAIL seq_req_addr: got %h ok=%0d expected %h", addr, ok, 32'(4 * k)); end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'h13) begin
        errors++; $display("FAIL seq_head: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=00000013", out_valid, out_pc, out_instr, 32'(4 * k));
      end
      checks++; if (out_fetcher_ready !== 1'b0) begin errors++; $display("FAIL seq_req_drop: got %b expected 0", out_fetcher_ready); end
    end
  endtask

  task automatic test_fill();
    logic [31:0] addr;
    bit ok, bad, seen;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      serve(1, 32'h00000093 | (32'(k) << 20), addr, ok);
      if (!ok || addr !== 32'(4 * k)) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL fill_addrs: got bad=%0d expected 0", bad); end
    seen = 1'b0;
    repeat (6) begin
      if (out_fetcher_ready) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL full_no_req: got req seen=%0d expected 0", seen); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL full_head: got v=%b pc=%h expected v=1 pc=00000000", out_valid, out_pc); end
    decoder_ready = 1'b1;
    tick();
    decoder_ready = 1'b0;
    checks++;
    if (out_pc !== 32'h4 || out_fetcher_ready !== 1'b0) begin
      errors++; $display("FAIL one_pop: got pc=%h req=%b expected pc=00000004 req=0", out_pc, out_fetcher_ready);
    end
    tick();
    checks++;
    if (out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h20) begin
      errors++; $display("FAIL refill_req: got req=%b addr=%h expected req=1 addr=00000020", out_fetcher_ready, fetch_addr);
    end
    decoder_ready = 1'b1;
    bad = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * (j + 1))) bad = 1'b1;
      tick();
    end
    checks++; if (bad || out_valid !== 1'b0) begin errors++; $display("FAIL drain_count7: got bad=%0d v=%b expected bad=0 v=0", bad, out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] addr;
    bit ok;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b0;
    for (int k = 0; k < 4; k++) serve(1, 32'h00000013, addr, ok);
    wait_req(ok);
    checks++; if (!ok || fetch_addr !== 32'h10) begin errors++; $display("FAIL flush_pre_addr: got %h expected 00000010", fetch_addr); end
    rob_clear = 1'b1; rob_new_pc = 32'h200;
    in_cache_ready = 1'b1; instr_addr_in = 32'h10; instr_in = 32'h13;
    tick();
    rob_clear = 1'b0; in_cache_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_fetcher_ready !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got v=%b req=%b expected v=0 req=0", out_valid, out_fetcher_ready);
    end
    tick();
    checks++;
    if (out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h200) begin
      errors++; $display("FAIL flush_redirect: got req=%b addr=%h expected req=1 addr=00000200", out_fetcher_ready, fetch_addr);
    end
    in_cache_ready = 1'b1; instr_addr_in = 32'h200; instr_in = 32'hABCDE037;
    tick();
    in_cache_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'hABCDE037) begin
      errors++; $display("FAIL flush_first_entry: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=abcde037", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_stale();
    logic [31:0] addr;
    bit ok;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b1;
    for (int k = 0; k < 8; k++) serve(2, 32'h00000013, addr, ok);
    wait_req(ok);
    checks++; if (!ok || fetch_addr !== 32'h20) begin errors++; $display("FAIL stale_pre_addr: got %h expected 00000020", fetch_addr); end
    in_cache_ready = 1'b1; instr_addr_in = 32'h1C; instr_in = 32'hDEADBEEF;
    tick();
    in_cache_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h20) begin
      errors++; $display("FAIL stale_drop: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000020", out_valid, out_fetcher_ready, fetch_addr);
    end
    tick(); tick();
    in_cache_ready = 1'b1; instr_addr_in = 32'h20; instr_in = 32'h00500113;
    tick();
    in_cache_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h00500113) begin
      errors++; $display("FAIL stale_then_good: got v=%b pc=%h instr=%h expected v=1 pc=00000020 instr=00500113", out_valid, out_pc, out_instr);
    end
    wait_req(ok);
    checks++; if (!ok || fetch_addr !== 32'h24) begin errors++; $display("FAIL stale_next_pc: got %h expected 00000024", fetch_addr); end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] addr;
    bit ok, bad;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b0;
    serve(1, 32'h00000013, addr, ok);
    serve(1, 32'h00000013, addr, ok);
    wait_req(ok);
    rdy = 1'b0; decoder_ready = 1'b1;
    in_cache_ready = 1'b1; instr_addr_in = 32'h8; instr_in = 32'h13;
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL freeze_hold: got bad=%0d expected 0", bad); end
    rdy = 1'b1; in_cache_ready = 1'b0;
    tick();
    checks++; if (out_pc !== 32'h4 || out_fetcher_ready !== 1'b1) begin errors++; $display("FAIL resume_pop1: got pc=%h req=%b expected pc=00000004 req=1", out_pc, out_fetcher_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_fetcher_ready !== 1'b1 || fetch_addr !== 32'h8) begin
      errors++; $display("FAIL resume_pop2: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000008", out_valid, out_fetcher_ready, fetch_addr);
    end
    in_cache_ready = 1'b1; instr_addr_in = 32'h8; instr_in = 32'h13;
    tick();
    in_cache_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin errors++; $display("FAIL resume_push: got v=%b pc=%h expected v=1 pc=00000008", out_valid, out_pc); end
  endtask

  task automatic test_jal();
    logic [31:0] addr, exp;
    bit ok;
    do_reset();
    cache_free = 1'b1; decoder_ready = 1'b1;
    for (int k = 0; k < 16; k++) serve(1, 32'h00000013, addr, ok);
    serve(1, 32'h0080006F, addr, ok);
    checks++; if (!ok || addr !== 32'h40) begin errors++; $display("FAIL jal_at: got %h expected 00000040", addr); end
    checks++;
    if (out_instr !== 32'h0080006F || out_pc !== 32'h40) begin
      errors++; $display("FAIL jal_entry: got instr=%h pc=%h expected instr=0080006f pc=00000040", out_instr, out_pc);
    end
`ifdef FETCH_JAL_PREDICT_EN
    exp = 32'h48;
`else
    exp = 32'h44;
`endif
    wait_req(ok);
    checks++; if (!ok || fetch_addr !== exp) begin errors++; $display("FAIL jal_fwd_target: got %h expected %h", fetch_addr, exp); end
    serve(1, 32'hFF9FF06F, addr, ok);
`ifdef FETCH_JAL_PREDICT_EN
    exp = addr - 32'd8;
`else
    exp = addr + 32'd4;
`endif
    wait_req(ok);
    checks++; if (!ok || fetch_addr !== exp) begin errors++; $display("FAIL jal_back_target: got %h expected %h", fetch_addr, exp); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] exp_pc;
    int wait_cnt, lat, low_run;
    bit prev_clear, ofr_now;
    do_reset();
    exp_pc = 32'h0; wait_cnt = 0; lat = 2; low_run = 0; prev_clear = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ofr_now = out_fetcher_ready;
      checks++;
      if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid: got %b expected %b", out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if ({out_instr, out_pc} !== q[0]) begin errors++; $display("FAIL rnd_head: got %h expected %h", {out_instr, out_pc}, q[0]); end
      end
      if (ofr_now) begin
        checks++;
        if (fetch_addr !== exp_pc || q.size() >= 8) begin errors++; $display("FAIL rnd_req: got addr=%h fill=%0d expected addr=%h fill<8", fetch_addr, q.size(), exp_pc); end
      end
      if (prev_clear) begin
        checks++;
        if (ofr_now !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_after_clear: got req=%b v=%b expected 0 0", ofr_now, out_valid); end
      end
      if (!ofr_now && q.size() < 8) low_run++; else low_run = 0;
      if (low_run > 60) begin
        checks++; errors++;
        $display("FAIL rnd_starved: got no request for %0d cycles expected one within 60", low_run);
        low_run = 0;
      end

      rdy = ($urandom_range(0, 9) != 0);
      cache_free = ($urandom_range(0, 9) < 7);
      decoder_ready = $urandom_range(0, 1) == 1;
      rob_clear = ($urandom_range(0, 59) == 0);
      rob_new_pc = $urandom & 32'hFFFF_FFFC;
      in_cache_ready = 1'b0; instr_in = $urandom; instr_addr_in = $urandom;
      if (ofr_now) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          in_cache_ready = 1'b1; instr_addr_in = exp_pc;
          wait_cnt = 0; lat = $urandom_range(1, 4);
        end else if ($urandom_range(0, 9) == 0) begin
          in_cache_ready = 1'b1; instr_addr_in = exp_pc ^ (32'd4 << $urandom_range(0, 5));
        end
      end else begin
        wait_cnt = 0;
        if ($urandom_range(0, 9) == 0) in_cache_ready = 1'b1;
      end

      if (rdy) begin
        if (rob_clear) begin
          q.delete();
          exp_pc = rob_new_pc;
        end else begin
          if (q.size() != 0 && decoder_ready) void'(q.pop_front());
          if (ofr_now && in_cache_ready && instr_addr_in == exp_pc) begin
            q.push_back({instr_in, instr_addr_in});
            exp_pc = ref_next(instr_in, instr_addr_in);
          end
        end
      end
      prev_clear = rdy && rob_clear;
      tick();
    end
    set_idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_flush();
    test_stale();
    test_rdy_freeze();
    test_jal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of the out-of-order RISC-V core. Holds the PC and issues one 32-bit instruction read at a time to the memory cache. It buffers returned instructions and their PCs in a small circular instruction queue that the decoder drains with a valid/ready handshake. On a RoB flush it discards all buffered and in-flight work and restarts at the redirect PC.

## Interface
Parameters:
- IQ_DEPTH_LOG, 3, log2 of instruction-queue depth (8 entries).
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low freezes all state.
- rob_clear  in  1  flush/redirect pulse from RoB.
- rob_new_pc  in  32  redirect target, valid with rob_clear.
- cache_free  in  1  cache idle and able to accept a request.
- out_fetcher_ready  out  1  fetch request to cache (cache's in_fetcher_ready).
- fetch_addr  out  32  request address (cache's instr_addr).
- in_cache_ready  in  1  cache response valid, one-cycle pulse.
- instr_in  in  32  returned instruction word.
- instr_addr_in  in  32  address of returned word.
- out_valid  out  1  queue head valid.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- decoder_ready  in  1  decoder accepts head this cycle.

## Operation
- State machine: IDLE, WAIT.
- IDLE: if cache_free and count < 2^IQ_DEPTH_LOG, then set out_fetcher_ready=1, fetch_addr=pc, and go to WAIT. Otherwise stay in IDLE with the request low.
- WAIT: hold out_fetcher_ready=1 and fetch_addr stable until a response arrives.
  - A valid response has in_cache_ready=1 and instr_addr_in==fetch_addr.
  - On a valid response: push {instr_in, instr_addr_in} at the tail, drop the request, advance pc (pc+4, mod 2^32), and go to IDLE.
  - Drop any response whose address mismatches (stale) and stay in WAIT.
- At most one request is outstanding. A queue slot is guaranteed, because issue requires count < depth and only a response pushes.
- Pop: when out_valid && decoder_ready, head advances and the entry is consumed.
- out_valid = (count != 0). out_instr and out_pc are the head entry, combinational from registered storage.
- Pointers are IQ_DEPTH_LOG bits and wrap modulo depth. count is IQ_DEPTH_LOG+1 bits.
- Simultaneous push and pop: both pointers advance and count is unchanged. A pop on empty is impossible (out_valid=0). Push on full cannot occur.
- rob_clear (with rdy high) has priority over all other activity:
  - head=tail=count=0, pc<=rob_new_pc, state<=IDLE, out_fetcher_ready<=0.
  - A response in the same cycle is discarded.
  - A pop in the same cycle is ignored.
- rst has priority over rob_clear and rdy.
- rdy low: no state changes and no push or pop. Outputs hold their registered values.

## Timing
- Reset values:
  - out_fetcher_ready=0, fetch_addr=RESET_PC, out_valid=0.
  - out_instr=0, out_pc=0 (storage cleared).
  - pc=RESET_PC, state=IDLE.
- The request rises on the edge after IDLE sees cache_free and space. It is registered, so it has no combinational path from cache_free.
- Response to out_valid: the pushed entry is visible at the head on the edge after in_cache_ready (1 cycle).
- Response to next request: at least 2 edges (WAIT→IDLE, IDLE→request).
- After rob_clear: out_valid=0 the next cycle. The first request at rob_new_pc rises at the earliest on the following edge.
- Decoder pop: at most one per cycle, taking effect at the clock edge.

## Configuration
- FETCH_JAL_PREDICT_EN defined: on a valid response whose instr_in[6:0]==7'b1101111 (JAL), the next pc is instr_addr_in + sign-extended J-immediate, {imm[20], imm[10:1], imm[11], imm[19:12]} with imm[0]=0, 32-bit wrap. The queue entry is unchanged. All other instructions use pc+4.
- Undefined: the next pc is always instr_addr_in+4. No decode logic is present.

## Test plan
- Reset with RESET_PC=0, cache_free=1, the cache returning 32'h00000013 per request with 3-cycle latency, decoder_ready=1 → requests at 0x0, 0x4, 0x8 in order; out_pc sequence 0x0, 0x4, 0x8; out_valid never high with a stale PC.
- decoder_ready=0, continuous responses → exactly 8 entries pushed, then out_fetcher_ready stays low. Raise decoder_ready for 1 cycle → one pop, count=7, one new request issued.
- A request to 0x10 is outstanding, then rob_clear with rob_new_pc=0x200 in the same cycle the response to 0x10 arrives → response dropped, out_valid=0 next cycle, next fetch_addr=0x200.
- In WAIT at 0x20, a response with instr_addr_in=0x1C → ignored, still in WAIT. A later response for 0x20 is pushed and pc=0x24.
- rdy=0 for 5 cycles during WAIT with decoder_ready=1 → no pops, pc, count and outputs unchanged; operation resumes identically when rdy=1.
- With FETCH_JAL_PREDICT_EN: instr_in=32'h0080006F (jal x0,+8) at 0x40 → next fetch_addr=0x48. Without the macro → next fetch_addr=0x44.
